// File: rtl/demultiplex_collector.sv
// demultiplex_collector: registered write-side demultiplexer.
// Scatters Width-bit words into a packed bank of 2**AddressSize slots, either
// by explicit address (Load) or through an auto-incrementing pointer (Push).
// It tracks which slots have been written and reports when the bank is full.
// Slot i lives at Q[i*Width +: Width], which matches the Multiplex selector packing.
module demultiplex_collector #(
  parameter int Width       = 8,
  parameter int AddressSize = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [Width-1:0]                  D,
  input  logic [AddressSize-1:0]            S,
  input  logic                              Load,
  input  logic                              Push,
  input  logic                              Clear,
  output logic [Width*(2**AddressSize)-1:0] Q,
  output logic [(2**AddressSize)-1:0]       Valid,
  output logic [AddressSize-1:0]            Ptr,
  output logic                              Full,
  output logic                              Done,
  output logic                              Overflow
);

  localparam int N = 2 ** AddressSize;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [Width*N-1:0]     bank_q, bank_d;
  logic [N-1:0]           valid_q, valid_d;
  logic [AddressSize-1:0] ptr_q, ptr_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;

  // Next-state logic. Commands are resolved as Clear, then Push, then Load,
  // so exactly one action takes place on each edge.
  always_comb begin
    // NOTE: each combinational output gets a default value first. Without these
    // defaults, any path that leaves a signal unassigned would infer a latch.
    state_d    = state_q;
    bank_d     = bank_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;

    if (Clear) begin
      state_d = ST_FILLING;
      bank_d  = '0;
      valid_d = '0;
      ptr_d   = '0;
    end else if (Push) begin
      if (state_q == ST_FULL) begin
        // The bank is complete. Reject the word and leave contents and pointer as they are.
        overflow_d = 1'b1;
      end else begin
        bank_d[int'(ptr_q)*Width +: Width] = D;
        valid_d[ptr_q]                     = 1'b1;
        // The pointer wraps from N-1 to 0 through natural modular overflow.
        ptr_d                              = ptr_q + AddressSize'(1);
      end
    end else if (Load) begin
      // An addressed write is accepted in either state and never moves the pointer.
      bank_d[int'(S)*Width +: Width] = D;
      valid_d[S]                     = 1'b1;
    end

    // Only a write made while filling can complete the bank. An idle cycle in
    // FILLING never has every valid bit set, so no extra qualifier is needed.
    if (!Clear && (state_q == ST_FILLING) && (&valid_d)) begin
      state_d = ST_FULL;
      done_d  = 1'b1;
    end
  end

  // State and bank registers, with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the bank is cleared on reset on purpose. A reset in the middle of
      // a fill must drop the partial contents, so this storage cannot be left
      // uninitialised the way a RAM would be.
      state_q    <= ST_FILLING;
      bank_q     <= '0;
      valid_q    <= '0;
      ptr_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples the values from before the edge, which avoids
      // ordering races between always blocks.
      state_q    <= state_d;
      bank_q     <= bank_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign Q        = bank_q;
  assign Valid    = valid_q;
  assign Ptr      = ptr_q;
  assign Full     = (state_q == ST_FULL);
  assign Done     = done_q;
  assign Overflow = overflow_q;

endmodule

// File: doc/demultiplex_collector.md
Name: demultiplex_collector

Overview:
- Registered demultiplexer: the write-side counterpart of the team's Multiplex selector.
- Scatters a stream of Width-bit words into a packed register bank of 2**AddressSize slots.
- Slot i occupies Q[i*Width +: Width], the same packing Multiplex uses. Feeding Q into Multiplex with select i returns the word written to slot i.
- Used to assemble chromosome/gene buses word by word, either by explicit address or by an auto-incrementing pointer, with per-slot valid tracking and full detection.

Parameters:
- Width, 8, bits per slot word
- AddressSize, 2, slot address bits; slot count N = 2**AddressSize

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  asynchronous reset, active-high
- D  input  Width  data word to write
- S  input  AddressSize  slot address for Load
- Load  input  1  write D into slot S
- Push  input  1  write D into slot Ptr, then advance Ptr
- Clear  input  1  synchronous clear of bank and state
- Q  output  Width*N  packed slot bank, registered
- Valid  output  N  bit i set once slot i has been written since last clear/reset
- Ptr  output  AddressSize  current auto-increment pointer
- Full  output  1  high while all Valid bits are set (state FULL)
- Done  output  1  one-cycle pulse on entry to FULL
- Overflow  output  1  one-cycle pulse when a Push is rejected in FULL

Behaviour:
- Reset (RST high, asynchronous, takes effect immediately regardless of CLK):
  - Q=0, Valid=0, Ptr=0, Full=0, Done=0, Overflow=0, state FILLING.
  - Reset asserted mid-sequence discards all partial contents.
- All outputs are registered. A write accepted at edge k is visible on Q/Valid/Ptr after edge k (latency 1).
- Command priority per cycle is Clear > Push > Load. Exactly one action occurs per edge; lower-priority commands that same cycle are dropped with no side effect.
- Clear: same values as reset, but synchronous. Clear has no effect on Done/Overflow beyond forcing them to 0 that cycle.
- FSM has two states.
- FILLING:
  - Load: slot S <= D; Valid[S] <= 1; Ptr unchanged.
  - Push: slot Ptr <= D; Valid[Ptr] <= 1; Ptr <= Ptr+1 modulo N (N-1 wraps to 0).
  - If the write leaves all N Valid bits set: next state FULL, Full <= 1, Done <= 1 for exactly that cycle.
- FULL:
  - Load: overwrites slot S; Valid stays all-ones; no Done pulse.
  - Push: rejected. Q, Valid and Ptr unchanged; Overflow <= 1 for one cycle. Consecutive rejected Pushes pulse Overflow every cycle.
  - Clear returns to FILLING. FULL is left only via Clear or RST.
- Done and Overflow are 0 in every cycle not specified above.
- Full is derived registered state and equals the AND of Valid at all times after reset.
- Mixing Load and Push:
  - Ptr advances only on Push; Load to an address ahead of Ptr does not move Ptr.
  - Push may rewrite an already-valid slot while FILLING. This is legal: data is overwritten and Valid stays 1.
- Width and AddressSize must be at least 1. N=2 (AddressSize=1) must work; the Ptr wrap is then a toggle.
- Inputs are sampled only at rising CLK; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert RST mid-cycle with CLK idle -> Q=0, Valid=0000, Ptr=0, Full=0, Done=0, Overflow=0 immediately.
- Sequential Push (Width=8, N=4) of 0x11, 0x22, 0x33, 0x44:
  - Q=0x44332211 after the fourth edge.
  - Ptr 1,2,3,0 after successive edges.
  - Done high only after the fourth edge; Full=1.
  - Multiplex on Q with S=0..3 yields 0x11, 0x22, 0x33, 0x44.
- Addressed Load in order S=2,0,3,1 with D=0xA2,0xA0,0xA3,0xA1:
  - Valid goes 0100, 0101, 1101, 1111.
  - Done pulses on the fourth write; Ptr stays 0; Q=0xA3A2A1A0.
- Overflow: from FULL, Push 0x55 on two consecutive cycles -> Q unchanged, Overflow high both cycles, Ptr unchanged. Then Load S=1 D=0x99 -> Q[15:8]=0x99, no Done.
- Priority: in the same cycle Clear=1, Push=1, Load=1 -> bank zeroed, Ptr=0. Next cycle Push=1, Load=1, S=3, D=0x7E -> only slot 0=0x7E, Valid=0001, Ptr=1.
- Reset mid-fill: Push 0x01, 0x02, assert RST, release, Push 0x03 -> Q=0x00000003, Valid=0001, Ptr=1.
